// File: rtl/bit_to_sfix36_en35.sv
// ============================================================================
// bit_to_sfix36_en35 : 10-bit code -> sfix36_En35 (code/1023), bit-serial restoring divide
// Rev 1.0 -- optional ROUND_NEAREST_EN adds a guard iteration for round-half-up
// ============================================================================
`default_nettype none

module bit_to_sfix36_en35 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  int_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] sfix36_En35_out
);

`ifdef ROUND_NEAREST_EN
  localparam int QW = 37;
`else
  localparam int QW = 36;
`endif

  localparam logic [5:0]  C_LAST_ITER = 6'(QW - 1);
  localparam logic [10:0] C_DIVISOR   = 11'd1023;
  localparam logic [35:0] C_SAT_MAX   = 36'h7_FFFF_FFFF;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [10:0]   r_rem;
  logic [10:0]   w_rem_shift;
  logic [10:0]   w_rem_next;
  logic [5:0]    r_iter;
  logic [QW-2:0] r_quot;
  logic [QW-1:0] w_quot_next;
  logic          w_bit;
  logic          w_last;
  logic [36:0]   w_q_ext;
  logic [35:0]   w_result;

  // Iteration 0 produces the integer bit, so the remainder is not doubled first.
  always_comb begin
    w_rem_shift = (r_iter == 6'd0) ? r_rem : {r_rem[9:0], 1'b0};
    w_bit       = (w_rem_shift >= C_DIVISOR);
    w_rem_next  = w_bit ? (w_rem_shift - C_DIVISOR) : w_rem_shift;
    w_quot_next = {r_quot, w_bit};
    w_last      = (r_iter == C_LAST_ITER);
  end

`ifdef ROUND_NEAREST_EN
  // Guard bit added to the truncated quotient gives round-half-up.
  assign w_q_ext = {1'b0, w_quot_next[36:1]} + 37'(w_quot_next[0]);
`else
  assign w_q_ext = {1'b0, w_quot_next};
`endif

  assign w_result = (|w_q_ext[36:35]) ? C_SAT_MAX : {1'b0, w_q_ext[34:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_DIV;
      S_DIV:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem           <= 11'd0;
      r_iter          <= 6'd0;
      r_quot          <= '0;
      sfix36_En35_out <= 36'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rem  <= {1'b0, int_in};
            r_iter <= 6'd0;
            r_quot <= '0;
          end
        end
        S_DIV: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next[QW-2:0];
          r_iter <= r_iter + 6'd1;
          if (w_last) begin
            sfix36_En35_out <= w_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_to_sfix36_en35.sv
// ============================================================================
// tb_bit_to_sfix36_en35 : scoreboard bench with arithmetic reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bit_to_sfix36_en35;

`ifdef ROUND_NEAREST_EN
  localparam int ITER = 37;
  localparam logic [35:0] C_EXP_1022 = 36'h7_FDFF_7FE0;
`else
  localparam int ITER = 36;
  localparam logic [35:0] C_EXP_1022 = 36'h7_FDFF_7FDF;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  int_in;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] sfix36_En35_out;

  int n_vec = 0;
  int n_err = 0;

  logic [35:0] exp_q[$];
  int          lat;
  bit          busy;
  bit          prev_valid;
  logic [35:0] prev_out;

  bit_to_sfix36_en35 dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .int_in          (int_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .sfix36_En35_out (sfix36_En35_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // code/1023 scaled by 2^35, floor or round-half-up, clamped to the max positive value
  function automatic logic [35:0] model(input logic [9:0] code);
    longint unsigned q;
`ifdef ROUND_NEAREST_EN
    q = ((64'(code) << 36) + 64'd1023) / 64'd2046;
`else
    q = (64'(code) << 35) / 64'd1023;
`endif
    if (q > 64'h7_FFFF_FFFF) q = 64'h7_FFFF_FFFF;
    return q[35:0];
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: scoreboard push on accept, pop on handshake, latency/stability/in_ready checks
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      busy       = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && out_valid)
        check("out_stable", sfix36_En35_out, prev_out);
      if (busy) begin
        check("in_ready_busy", 36'(in_ready), 36'd0);
        if (out_valid) begin
          check("latency", 36'(lat), 36'(ITER));
          busy = 1'b0;
        end else begin
          lat++;
          if (lat > 200) begin
            check("latency_timeout", 36'(lat), 36'(ITER));
            busy = 1'b0;
          end
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", sfix36_En35_out, 36'hX);
        end else begin
          check("scoreboard", sfix36_En35_out, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int_in));
        busy = 1'b1;
        lat  = 0;
      end
      prev_valid = out_valid;
      prev_out   = sfix36_En35_out;
    end
  end

  task automatic accept(input logic [9:0] code);
    int i;
    for (i = 0; i < 100 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) check("accept_timeout", 36'(in_ready), 36'd1);
    in_valid = 1'b1;
    int_in   = code;
    @(posedge clk); #1;
    in_valid = 1'b0;
    int_in   = 10'($urandom);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    check("out_valid_timeout", 36'(out_valid), 36'd1);
  endtask

  task automatic convert(input logic [9:0] code, input logic [35:0] want);
    bit ok;
    out_ready = 1'b1;
    accept(code);
    wait_valid(ok);
    if (ok) check("directed_out", sfix36_En35_out, want);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] held;
    logic [9:0]  code;
    bit          ok;

    rst = 1'b1; in_valid = 1'b0; int_in = 10'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 36'(in_ready), 36'd1);
    check("rst_out_valid", 36'(out_valid), 36'd0);
    check("rst_out", sfix36_En35_out, 36'd0);

    convert(10'd0,    36'h0_0000_0000);
    convert(10'd512,  36'h4_0100_4010);
    convert(10'd1,    36'h0_0200_8020);
    convert(10'd1022, C_EXP_1022);
    convert(10'd1023, 36'h7_FFFF_FFFF);

    // Backpressure: DONE must hold while stray in_valid pulses are ignored
    out_ready = 1'b0;
    accept(10'd300);
    wait_valid(ok);
    held = sfix36_En35_out;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom);
      int_in   = 10'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 36'(out_valid), 36'd1);
      check("hold_out", sfix36_En35_out, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 36'(in_ready), 36'd1);
    check("release_out_valid", 36'(out_valid), 36'd0);
    in_valid = 1'b1;
    int_in   = 10'd77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("next_accept", 36'(in_ready), 36'd0);
    wait_valid(ok);
    @(posedge clk); #1;

    // Reset mid-conversion abandons the result
    accept(10'd700);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 36'(in_ready), 36'd1);
    check("abort_out_valid", 36'(out_valid), 36'd0);
    check("abort_out", sfix36_En35_out, 36'd0);
    convert(10'd512, 36'h4_0100_4010);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0:       code = 10'd0;
        1:       code = 10'd1023;
        2:       code = 10'd1022;
        default: code = 10'($urandom);
      endcase
      out_ready = 1'b0;
      accept(code);
      wait_valid(ok);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 36'(exp_q.size()), 36'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bit_to_sfix36_en35.md
# bit_to_sfix36_en35

Sequential converter from a 10-bit unsigned code to signed fixed-point sfix36_En35, computing code/1023 by bit-serial restoring division. It is the inverse of the existing sfix36_En35 → 10-bit scaler and feeds captured 10-bit sample codes back into the fixed-point datapath. Valid/ready handshake on both sides; one conversion in flight at a time.

## Interface
- No parameters. Widths are fixed: 10-bit input, 36-bit output, divisor constant 1023.
- clk  input  1  sole clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  int_in is valid
- in_ready  output  1  block can accept; high only in IDLE
- int_in  input  10  unsigned code, 0..1023
- out_valid  output  1  sfix36_En35_out holds a finished result
- out_ready  input  1  consumer accepts the result
- sfix36_En35_out  output  36  signed result, 35 fractional bits

## Operation
- States: IDLE, DIV, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, load remainder R=int_in (11-bit register), clear quotient, set iteration counter to 0, go to DIV.
- DIV: one quotient bit per cycle, MSB first. Iteration 0 (integer bit): if R≥1023 then bit=1, R-=1023, else bit=0; no shift. Iterations 1..35: R=2R; if R≥1023 then bit=1, R-=1023, else bit=0. R stays <1023 after every iteration.
- After the last iteration, form the result q (36-bit, unsigned value code·2^35/1023), saturate, load sfix36_En35_out, go to DONE.
- Saturation: q≥2^35 (only code 1023) → 0x7FFFFFFFF (2^35−1). Output is never negative; sign bit is always 0.
- DONE: out_valid=1, sfix36_En35_out stable. On out_ready, go to IDLE. int_in and in_valid are ignored outside IDLE.
- Reset in any state: abandon conversion, go to IDLE, no result emitted.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, sfix36_En35_out=0, R=0, counter=0.
- Accept on edge E0. Iterations on edges E1..E36 (truncating build). out_valid goes high after E36 and stays high until out_ready is sampled high.
- Result consumed on edge Ed (out_valid&&out_ready). in_ready goes high after Ed. A new input cannot be accepted on Ed itself.
- Minimum period between accepts with out_ready held at 1: 38 cycles (39 with rounding).
- in_ready is decoded from state only; no combinational path from in_valid or out_ready.
- Backpressure: DONE holds its value indefinitely; sfix36_En35_out changes only on the DIV→DONE edge or on reset.

## Configuration
- ROUND_NEAREST_EN defined: one extra guard iteration, iteration 36, using the same shift/compare. Result = q + guard bit, which is round-half-up, then saturated. Latency is 37 iteration edges.
- Not defined: truncation (floor). 36 iteration edges.

## Test plan
- Reset, then int_in=0 accepted → after 36 edges out_valid=1, out=0x000000000; in_ready=0 throughout DIV/DONE.
- int_in=512 → 0x401004010 (both builds). int_in=1 → 0x002008020 (both builds).
- int_in=1022 → 0x7FDFF7FDF (truncating), 0x7FDFF7FE0 (ROUND_NEAREST_EN).
- int_in=1023 → saturated 0x7FFFFFFFF in both builds.
- Hold out_ready=0 for 20 cycles in DONE → out_valid and out stay stable, in_valid pulses ignored. Raise out_ready → IDLE next edge, and the next code is accepted the cycle after.
- Assert rst at iteration 10 of int_in=700 → next cycle IDLE, out_valid=0, out=0. A following int_in=512 still yields 0x401004010.
